vga_timing_ce: RTL and testbench

// - Parametrised VGA timing generator; successor to the fixed 640x480 timing path, which

---
 rtl/vga_pkg.sv | 20 ++
 rtl/clk_en_div.sv | 31 +++
 rtl/vga_timing_ce.sv | 152 +++++++++++++++
 tb/tb_vga_timing_ce.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and helpers.
package vga_pkg;

    localparam int VGA_CE_DIV   = 4;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_CNT_W    = 11;
    localparam int VGA_FRAME_W  = 16;

    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// Pixel clock-enable divider: one-cycle PixCE every CE_DIV cycles of CLK100M.
module clk_en_div #(
    parameter int CE_DIV = 4
) (
    input  logic CLK100M,
    input  logic Reset,
    input  logic Enable,
    output logic PixCE
);

    localparam int DIV_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (Enable) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge CLK100M) begin
        if (Reset) div_q <= '0;
        else       div_q <= div_d;
    end

    // Gated with Reset so CE_DIV=1 cannot strobe while the counters are held.
    assign PixCE = Enable && !Reset && (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_ce.sv
// Parametrised VGA timing generator on a single clock, pixel rate set by a clock enable.
module vga_timing_ce
    import vga_pkg::*;
#(
    parameter int   CE_DIV   = VGA_CE_DIV,
    parameter int   H_ACTIVE = VGA_H_ACTIVE,
    parameter int   H_FP     = VGA_H_FP,
    parameter int   H_SYNC   = VGA_H_SYNC,
    parameter int   H_BP     = VGA_H_BP,
    parameter int   V_ACTIVE = VGA_V_ACTIVE,
    parameter int   V_FP     = VGA_V_FP,
    parameter int   V_SYNC   = VGA_V_SYNC,
    parameter int   V_BP     = VGA_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CNT_W    = VGA_CNT_W,
    parameter int   FRAME_W  = VGA_FRAME_W
) (
    input  logic               CLK100M,
    input  logic               Reset,
    input  logic               Enable,
    output logic               PixCE,
    output logic               Vde,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic [CNT_W-1:0]   HCnt,
    output logic [CNT_W-1:0]   VCnt,
    output logic               LineStart,
    output logic               FrameStart,
    output logic               VBlankStart,
    output logic [FRAME_W-1:0] FrameCnt
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    if ((H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_cnt_w_chk
        $error("vga_timing_ce: H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W bits");
    end

    logic pix_ce;

    clk_en_div #(.CE_DIV(CE_DIV)) u_div (
        .CLK100M (CLK100M),
        .Reset   (Reset),
        .Enable  (Enable),
        .PixCE   (pix_ce)
    );

    // nx/ny hold the coordinate to present on the next PixCE; the output
    // registers hold the one currently presented, so all outputs move together.
    logic [CNT_W-1:0]   nx_q, nx_d, ny_q, ny_d;
    logic [CNT_W-1:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic               vde_q, vde_d, hs_q, hs_d, vs_q, vs_d;
    logic               ls_q, ls_d, fs_q, fs_d, vbs_q, vbs_d;
    logic [FRAME_W-1:0] fcnt_q, fcnt_d;
    logic               seen_q, seen_d;

    logic at_x0, at_y0, in_hs, in_vs, in_vis;

    assign at_x0  = (nx_q == '0);
    assign at_y0  = (ny_q == '0);
    assign in_vis = (int'(nx_q) < H_ACTIVE) && (int'(ny_q) < V_ACTIVE);
    assign in_hs  = (int'(nx_q) >= H_ACTIVE + H_FP) && (int'(nx_q) < H_ACTIVE + H_FP + H_SYNC);
    assign in_vs  = (int'(ny_q) >= V_ACTIVE + V_FP) && (int'(ny_q) < V_ACTIVE + V_FP + V_SYNC);

    always_comb begin
        nx_d   = nx_q;
        ny_d   = ny_q;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        vde_d  = vde_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        ls_d   = ls_q;
        fs_d   = fs_q;
        vbs_d  = vbs_q;
        fcnt_d = fcnt_q;
        seen_d = seen_q;
        // Strobes last one CLK100M cycle; with Enable low everything is frozen.
        if (Enable) begin
            ls_d  = 1'b0;
            fs_d  = 1'b0;
            vbs_d = 1'b0;
        end
        if (pix_ce) begin
            hcnt_d = nx_q;
            vcnt_d = ny_q;
            vde_d  = in_vis;
            hs_d   = in_hs ? HS_POL : ~HS_POL;
            vs_d   = in_vs ? VS_POL : ~VS_POL;
            ls_d   = at_x0;
            fs_d   = at_x0 && at_y0;
            vbs_d  = at_x0 && (int'(ny_q) == V_ACTIVE);
            // The first frame after reset is not a completed frame.
            if (at_x0 && at_y0) begin
                if (seen_q) fcnt_d = fcnt_q + 1'b1;
                seen_d = 1'b1;
            end
            if (nx_q == H_LAST) begin
                nx_d = '0;
                ny_d = (ny_q == V_LAST) ? '0 : ny_q + 1'b1;
            end else begin
                nx_d = nx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK100M) begin
        if (Reset) begin
            nx_q   <= '0;
            ny_q   <= '0;
            hcnt_q <= '0;
            vcnt_q <= '0;
            vde_q  <= 1'b0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            vbs_q  <= 1'b0;
            fcnt_q <= '0;
            seen_q <= 1'b0;
        end else begin
            nx_q   <= nx_d;
            ny_q   <= ny_d;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            vde_q  <= vde_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
            vbs_q  <= vbs_d;
            fcnt_q <= fcnt_d;
            seen_q <= seen_d;
        end
    end

    assign PixCE       = pix_ce;
    assign Vde         = vde_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign HCnt        = hcnt_q;
    assign VCnt        = vcnt_q;
    assign LineStart   = ls_q;
    assign FrameStart  = fs_q;
    assign VBlankStart = vbs_q;
    assign FrameCnt    = fcnt_q;

endmodule

// File: tb/tb_vga_timing_ce.sv
// Directed bench: default 640x480 timing, a small CE_DIV=4 geometry and the CE_DIV=1 table.
module tb_vga_timing_ce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // a: defaults; b: CE_DIV=1 small, HS_POL=1, FRAME_W=2; c: CE_DIV=4 small geometry
    logic rst_a = 1'b1, en_a = 1'b1;
    logic rst_b = 1'b1, en_b = 1'b1;
    logic rst_c = 1'b1, en_c = 1'b1;

    logic        pix_a, vde_a, hs_a, vs_a, ls_a, fs_a, vbs_a;
    logic [10:0] hc_a, vc_a;
    logic [15:0] fc_a;
    logic        pix_b, vde_b, hs_b, vs_b, ls_b, fs_b, vbs_b;
    logic [10:0] hc_b, vc_b;
    logic [1:0]  fc_b;
    logic        pix_c, vde_c, hs_c, vs_c, ls_c, fs_c, vbs_c;
    logic [10:0] hc_c, vc_c;
    logic [15:0] fc_c;

    vga_timing_ce dut_a (
        .CLK100M(clk), .Reset(rst_a), .Enable(en_a), .PixCE(pix_a), .Vde(vde_a),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .HCnt(hc_a), .VCnt(vc_a), .LineStart(ls_a),
        .FrameStart(fs_a), .VBlankStart(vbs_a), .FrameCnt(fc_a));

    vga_timing_ce #(.CE_DIV(1), .HS_POL(1'b1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .FRAME_W(2)) dut_b (
        .CLK100M(clk), .Reset(rst_b), .Enable(en_b), .PixCE(pix_b), .Vde(vde_b),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .HCnt(hc_b), .VCnt(vc_b), .LineStart(ls_b),
        .FrameStart(fs_b), .VBlankStart(vbs_b), .FrameCnt(fc_b));

    vga_timing_ce #(.CE_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut_c (
        .CLK100M(clk), .Reset(rst_c), .Enable(en_c), .PixCE(pix_c), .Vde(vde_c),
        .VGA_HS(hs_c), .VGA_VS(vs_c), .HCnt(hc_c), .VCnt(vc_c), .LineStart(ls_c),
        .FrameStart(fs_c), .VBlankStart(vbs_c), .FrameCnt(fc_c));

    typedef struct {
        int         adv;
        int         h, v;
        logic       vde, hs, vs, ls, fs, vb;
        logic [1:0] fc;
    } vec_t;

    vec_t tbl[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        int cyc, hs_cnt, hs_min, hs_max, first_blank, vde_bad, vs_cnt, vs_bad;
        logic ok;

        // x, y, vde, hs, vs, ls, fs, vb, fc for CE_DIV=1: presented index p = edges-1
        tbl[0]  = '{1,   0, 0, 1, 0, 1, 1, 1, 0, 2'd0};
        tbl[1]  = '{1,   1, 0, 1, 0, 1, 0, 0, 0, 2'd0};
        tbl[2]  = '{6,   7, 0, 1, 0, 1, 0, 0, 0, 2'd0};
        tbl[3]  = '{1,   8, 0, 0, 0, 1, 0, 0, 0, 2'd0};
        tbl[4]  = '{2,  10, 0, 0, 1, 1, 0, 0, 0, 2'd0};
        tbl[5]  = '{1,  11, 0, 0, 1, 1, 0, 0, 0, 2'd0};
        tbl[6]  = '{1,  12, 0, 0, 0, 1, 0, 0, 0, 2'd0};
        tbl[7]  = '{2,   0, 1, 1, 0, 1, 1, 0, 0, 2'd0};
        tbl[8]  = '{42,  0, 4, 0, 0, 1, 1, 0, 1, 2'd0};
        tbl[9]  = '{14,  0, 5, 0, 0, 0, 1, 0, 0, 2'd0};
        tbl[10] = '{13, 13, 5, 0, 0, 0, 0, 0, 0, 2'd0};
        tbl[11] = '{1,   0, 6, 0, 0, 1, 1, 0, 0, 2'd0};
        tbl[12] = '{14,  0, 0, 1, 0, 1, 1, 1, 0, 2'd1};
        tbl[13] = '{98,  0, 0, 1, 0, 1, 1, 1, 0, 2'd2};
        tbl[14] = '{98,  0, 0, 1, 0, 1, 1, 1, 0, 2'd3};
        tbl[15] = '{97, 13, 6, 0, 0, 1, 0, 0, 0, 2'd3};
        tbl[16] = '{1,   0, 0, 1, 0, 1, 1, 1, 0, 2'd0};

        repeat (3) tick();

        // Reset state of all three instances
        chk("rst_a_pix", pix_a, 0); chk("rst_a_hc", hc_a, 0); chk("rst_a_vde", vde_a, 0);
        chk("rst_a_hs", hs_a, 1);   chk("rst_a_vs", vs_a, 1); chk("rst_a_fs", fs_a, 0);
        chk("rst_b_pix", pix_b, 0); chk("rst_b_hs", hs_b, 0); chk("rst_b_vs", vs_b, 1);
        chk("rst_b_fc", fc_b, 0);   chk("rst_c_ls", ls_c, 0); chk("rst_c_vc", vc_c, 0);

        // Defaults: PixCE on every 4th cycle, first one presents (0,0)
        rst_a = 1'b0;
        tick(); chk("a_pix1", pix_a, 0);
        tick(); chk("a_pix2", pix_a, 0);
        tick(); chk("a_pix3", pix_a, 1); chk("a_hc_pre", hc_a, 0); chk("a_fs_pre", fs_a, 0);
        tick(); chk("a_pix4", pix_a, 0);
        chk("a_first_hc", hc_a, 0); chk("a_first_vc", vc_a, 0); chk("a_first_vde", vde_a, 1);
        chk("a_first_fs", fs_a, 1); chk("a_first_ls", ls_a, 1); chk("a_first_fc", fc_a, 0);
        chk("a_first_hs", hs_a, 1); chk("a_first_vs", vs_a, 1); chk("a_first_vbs", vbs_a, 0);

        // One full line
        cyc = 0; hs_cnt = 0; hs_min = 9999; hs_max = -1; first_blank = -1; vde_bad = 0;
        ok = 1'b0;
        while (cyc < 5000) begin
            tick(); cyc++;
            if (cyc == 1) begin
                chk("a_fs_pulse", fs_a, 0);
                chk("a_ls_pulse", ls_a, 0);
            end
            if (ls_a) begin ok = 1'b1; break; end
            if (!hs_a) begin
                hs_cnt++;
                if (int'(hc_a) < hs_min) hs_min = int'(hc_a);
                if (int'(hc_a) > hs_max) hs_max = int'(hc_a);
            end
            if (!vde_a && first_blank < 0) first_blank = int'(hc_a);
            if (vde_a != (hc_a < 11'd640)) vde_bad++;
        end
        chk("a_line_timeout", ok, 1);
        chk("a_line_period", cyc, 3200);
        chk("a_line_vc", vc_a, 1);
        chk("a_hs_cycles", hs_cnt, 384);
        chk("a_hs_first_x", hs_min, 656);
        chk("a_hs_last_x", hs_max, 751);
        chk("a_vde_first_blank", first_blank, 640);
        chk("a_vde_bad", vde_bad, 0);

        // Enable=0 for 10 cycles at (100,5)
        cyc = 0; ok = 1'b0;
        while (cyc < 20000) begin
            tick(); cyc++;
            if (hc_a == 11'd100 && vc_a == 11'd5) begin ok = 1'b1; break; end
        end
        chk("a_en_timeout", ok, 1);
        en_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("a_frz_pix", pix_a, 0); chk("a_frz_hc", hc_a, 100); chk("a_frz_vc", vc_a, 5);
            chk("a_frz_vde", vde_a, 1); chk("a_frz_hs", hs_a, 1);
        end
        en_a = 1'b1;
        tick(); tick();
        chk("a_res_pix2", pix_a, 0);
        tick();
        chk("a_res_pix3", pix_a, 1); chk("a_res_hc3", hc_a, 100);
        tick();
        chk("a_res_hc", hc_a, 101); chk("a_res_vc", vc_a, 5); chk("a_res_pix4", pix_a, 0);

        // CE_DIV=1 table
        rst_b = 1'b0;
        for (int i = 0; i < 17; i++) begin
            repeat (tbl[i].adv) tick();
            chk($sformatf("b%0d_pix", i), pix_b, 1);
            chk($sformatf("b%0d_hc", i), hc_b, tbl[i].h);
            chk($sformatf("b%0d_vc", i), vc_b, tbl[i].v);
            chk($sformatf("b%0d_vde", i), vde_b, tbl[i].vde);
            chk($sformatf("b%0d_hs", i), hs_b, tbl[i].hs);
            chk($sformatf("b%0d_vs", i), vs_b, tbl[i].vs);
            chk($sformatf("b%0d_ls", i), ls_b, tbl[i].ls);
            chk($sformatf("b%0d_fs", i), fs_b, tbl[i].fs);
            chk($sformatf("b%0d_vb", i), vbs_b, tbl[i].vb);
            chk($sformatf("b%0d_fc", i), fc_b, tbl[i].fc);
        end

        // Small CE_DIV=4 geometry: frame, vblank and vsync timing
        rst_c = 1'b0;
        cyc = 0; ok = 1'b0;
        while (cyc < 20) begin tick(); cyc++; if (fs_c) begin ok = 1'b1; break; end end
        chk("c_fs1_timeout", ok, 1);
        chk("c_fs1_lat", cyc, 4); chk("c_fs1_hc", hc_c, 0); chk("c_fs1_fc", fc_c, 0);
        cyc = 0; ok = 1'b0;
        while (cyc < 1000) begin tick(); cyc++; if (vbs_c) begin ok = 1'b1; break; end end
        chk("c_vb_timeout", ok, 1);
        chk("c_vb_delay", cyc, 224); chk("c_vb_hc", hc_c, 0); chk("c_vb_vc", vc_c, 4);
        chk("c_vb_vde", vde_c, 0);
        tick(); cyc++;
        chk("c_vb_pulse", vbs_c, 0);
        vs_cnt = 0; vs_bad = 0; ok = 1'b0;
        while (cyc < 1000) begin
            tick(); cyc++;
            if (fs_c) begin ok = 1'b1; break; end
            if (!vs_c) begin vs_cnt++; if (vc_c != 11'd5) vs_bad++; end
        end
        chk("c_fs2_timeout", ok, 1);
        chk("c_frame_period", cyc, 392);
        chk("c_vs_cycles", vs_cnt, 56); chk("c_vs_bad", vs_bad, 0);
        chk("c_fs2_fc", fc_c, 1);

        // Reset mid-frame
        cyc = 0; ok = 1'b0;
        while (cyc < 1000) begin
            tick(); cyc++;
            if (hc_c == 11'd3 && vc_c == 11'd2) begin ok = 1'b1; break; end
        end
        chk("c_mid_timeout", ok, 1);
        rst_c = 1'b1;
        tick();
        chk("c_rst_hc", hc_c, 0); chk("c_rst_vc", vc_c, 0); chk("c_rst_vde", vde_c, 0);
        chk("c_rst_hs", hs_c, 1); chk("c_rst_vs", vs_c, 1); chk("c_rst_fc", fc_c, 0);
        chk("c_rst_pix", pix_c, 0); chk("c_rst_fs", fs_c, 0);
        rst_c = 1'b0;
        cyc = 0; ok = 1'b0;
        while (cyc < 10) begin tick(); cyc++; if (pix_c) begin ok = 1'b1; break; end end
        chk("c_rel_timeout", ok, 1);
        tick();
        chk("c_rel_hc", hc_c, 0); chk("c_rel_vc", vc_c, 0); chk("c_rel_fs", fs_c, 1);
        chk("c_rel_ls", ls_c, 1); chk("c_rel_fc", fc_c, 0); chk("c_rel_vde", vde_c, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
